// File: rtl/sincos_lut_if.sv
// ---------------------------------------------------------------------------
// sincos_lut_if
//
// Purpose
//   Bundles the lookup stream and the table write port of sincos_lut so that
//   the FOC datapath connects one handle instead of eight loose wires.
//
// Signals
//   ang_i      [ANG_W-1:0]   angle code, 0 = 0 deg, 2^(ANG_W-2) = 90 deg
//   ang_vld_i                ang_i valid this cycle
//   sin_o      [DATA_W-1:0]  signed sine, updated only when out_vld_o = 1
//   cos_o      [DATA_W-1:0]  signed cosine, updated only when out_vld_o = 1
//   out_vld_o                sin_o / cos_o carry a new result this cycle
//   wr_en_i                  table write strobe
//   wr_addr_i  [ANG_W-2:0]   table index 0..Q (larger indices are dropped)
//   wr_data_i  [DATA_W-2:0]  unsigned magnitude for that entry
//
// Modports
//   master : the side that issues angles and table writes
//   slave  : the lookup block itself
// ---------------------------------------------------------------------------
interface sincos_lut_if #(
    parameter int ANG_W  = 10,
    parameter int DATA_W = 16
);

    logic [ANG_W-1:0]         ang_i;
    logic                     ang_vld_i;
    logic signed [DATA_W-1:0] sin_o;
    logic signed [DATA_W-1:0] cos_o;
    logic                     out_vld_o;
    logic                     wr_en_i;
    logic [ANG_W-2:0]         wr_addr_i;
    logic [DATA_W-2:0]        wr_data_i;

    modport master (
        output ang_i,
        output ang_vld_i,
        output wr_en_i,
        output wr_addr_i,
        output wr_data_i,
        input  sin_o,
        input  cos_o,
        input  out_vld_o
    );

    modport slave (
        input  ang_i,
        input  ang_vld_i,
        input  wr_en_i,
        input  wr_addr_i,
        input  wr_data_i,
        output sin_o,
        output cos_o,
        output out_vld_o
    );

endinterface

// File: rtl/sincos_lut.sv
// ---------------------------------------------------------------------------
// sincos_lut
//
// Purpose
//   Pipelined quarter-wave sine/cosine lookup. A single table of Q+1
//   unsigned magnitudes covers 0..90 degrees; the two top angle bits pick
//   the quadrant, which decides which of T[i] / T[Q-i] feeds each output
//   and whether it is negated. One angle is accepted per clock, results
//   leave three clocks later in issue order. The table is reloadable at run
//   time through a dedicated write port.
//
// Parameters
//   ANG_W      angle width, full circle = 2^ANG_W codes (ANG_W >= 3)
//   DATA_W     signed output width
//   INIT_FILE  table image name; contents are undefined until written
//
// Ports
//   sys_clk    clock, everything on the rising edge
//   rst        asynchronous, active-high; clears pipeline valids and
//              outputs, never the table
//   bus        sincos_lut_if.slave (angle stream, results, table write)
//
// Pipeline
//   S1  quadrant q, index i, mirrored index j = Q - i, valid
//   S2  T[i], T[j] (registered table reads), q, valid
//   S3  sign/swap applied, sin_o / cos_o / out_vld_o registered
// ---------------------------------------------------------------------------
module sincos_lut #(
    parameter int ANG_W     = 10,
    parameter int DATA_W    = 16,
    parameter     INIT_FILE = ""
) (
    input  logic          sys_clk,
    input  logic          rst,
    sincos_lut_if.slave   bus
);

    // Quarter size and the widths derived from it. The table spans 0..Q
    // inclusive, so its address needs one bit more than the in-quadrant
    // index i.
    localparam int Q      = 2 ** (ANG_W - 2);
    localparam int IDX_W  = ANG_W - 2;
    localparam int ADDR_W = ANG_W - 1;
    localparam int MAG_W  = DATA_W - 1;

    localparam logic [ADDR_W-1:0] Q_ADDR = ADDR_W'(Q);

    // -----------------------------------------------------------------------
    // Quarter-wave table: two read ports (i and j), one write port.
    // -----------------------------------------------------------------------
    logic [MAG_W-1:0] tbl [0:Q];

    // -----------------------------------------------------------------------
    // S1: angle decode
    // -----------------------------------------------------------------------
    logic [1:0]        s1_q_reg;
    logic [IDX_W-1:0]  s1_i_reg;
    logic [ADDR_W-1:0] s1_j_reg;
    logic              s1_vld_reg;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            s1_q_reg   <= '0;
            s1_i_reg   <= '0;
            s1_j_reg   <= '0;
            s1_vld_reg <= 1'b0;
        end else begin
            s1_vld_reg <= bus.ang_vld_i;
            s1_q_reg   <= bus.ang_i[ANG_W-1 -: 2];
            s1_i_reg   <= bus.ang_i[IDX_W-1:0];
            // j lands in 1..Q, so it needs the extra address bit.
            s1_j_reg   <= Q_ADDR - {1'b0, bus.ang_i[IDX_W-1:0]};
        end
    end

    // -----------------------------------------------------------------------
    // S2: table access. The table and its read registers carry no reset so
    // they map onto block RAM with its output register. A non-blocking read
    // of an entry written at the same edge returns the old contents, which
    // gives read-before-write; a write one edge earlier is already visible.
    // -----------------------------------------------------------------------
    logic [MAG_W-1:0] s2_ti_reg;
    logic [MAG_W-1:0] s2_tj_reg;
    logic [1:0]       s2_q_reg;
    logic             s2_vld_reg;

    always_ff @(posedge sys_clk) begin
        // Indices above Q address no entry and are simply dropped.
        if (bus.wr_en_i && (bus.wr_addr_i <= Q_ADDR)) begin
            tbl[bus.wr_addr_i] <= bus.wr_data_i;
        end
        s2_ti_reg <= tbl[{1'b0, s1_i_reg}];
        s2_tj_reg <= tbl[s1_j_reg];
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            s2_q_reg   <= '0;
            s2_vld_reg <= 1'b0;
        end else begin
            s2_q_reg   <= s1_q_reg;
            s2_vld_reg <= s1_vld_reg;
        end
    end

    // -----------------------------------------------------------------------
    // S3: quadrant folding, one generate lane per output (0 = sin, 1 = cos).
    //
    //   q | sin    | cos
    //   0 | +T[i]  | +T[j]
    //   1 | +T[j]  | -T[i]
    //   2 | -T[i]  | -T[j]
    //   3 | -T[j]  | +T[i]
    //
    // sin takes T[j] in the odd quadrants and cos takes it in the even ones,
    // so the swap select is q[0] inverted for the cos lane. sin is negative
    // in the lower half-plane (q[1]); cos is negative in quadrants 1 and 2
    // (q[1] ^ q[0]). Magnitudes are zero-extended before negation, so -0
    // stays 0 and -T never overflows.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            localparam bit IS_COS = (gi == 1);

            logic              swap;
            logic              neg;
            logic [DATA_W-1:0] mag_ext;
            logic [DATA_W-1:0] res_reg;

            assign swap    = s2_q_reg[0] ^ IS_COS;
            assign neg     = s2_q_reg[1] ^ (IS_COS & s2_q_reg[0]);
            assign mag_ext = {1'b0, (swap ? s2_tj_reg : s2_ti_reg)};

            // Bubbles leave the previous result in place.
            always_ff @(posedge sys_clk or posedge rst) begin
                if (rst) begin
                    res_reg <= '0;
                end else if (s2_vld_reg) begin
                    res_reg <= neg ? (-mag_ext) : mag_ext;
                end
            end
        end
    endgenerate

    logic out_vld_reg;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            out_vld_reg <= 1'b0;
        end else begin
            out_vld_reg <= s2_vld_reg;
        end
    end

    assign bus.sin_o     = g_ch[0].res_reg;
    assign bus.cos_o     = g_ch[1].res_reg;
    assign bus.out_vld_o = out_vld_reg;

endmodule
